sparse_chunk_writer: RTL and testbench

- Producer end of the compute cluster's chunk write interface (sparsemap, nonzero data, wr_valid, wr_count, wr_sel, cu_wr_sel).
- Accepts dense byte beats on a valid/ready stream and encodes each beat into a sparsemap plus left-packed nonzero bytes.
- Drives one chunk of WR_DAT_CYC_NUM beats into one of two ping-pong banks, and tracks bank occupancy against release pulses from the controller.
- One instance feeds IFM, another feeds filters; the filter instance uses the rotating per-compute-unit select.

---
 rtl/sparse_chunk_writer.sv | 140 ++++++++++++++
 tb/tb_sparse_chunk_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_chunk_writer.sv
// Producer side of the cluster chunk write interface: dense beats are turned into a sparsemap plus
// left-packed nonzero bytes and written in chunks into two ping-pong banks.
module sparse_chunk_writer #(
    parameter int BUS_SIZE       = 16,
    parameter int WR_DAT_CYC_NUM = 8,
    parameter int CU_NUM         = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [BUS_SIZE*8-1:0]             in_data_i,
    input  logic [1:0]                        release_i,
    output logic [BUS_SIZE-1:0]               sparsemap_o,
    output logic [BUS_SIZE*8-1:0]             nonzero_data_o,
    output logic [$clog2(BUS_SIZE):0]         nz_count_o,
    output logic                              chunk_wr_valid_o,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0] chunk_wr_count_o,
    output logic                              chunk_wr_sel_o,
    output logic [CU_NUM-1:0]                 cu_wr_sel_o,
    output logic [1:0]                        bank_full_o,
    output logic                              chunk_done_o
);

    localparam int NZ_W  = $clog2(BUS_SIZE) + 1;
    localparam int CNT_W = $clog2(WR_DAT_CYC_NUM);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WR_DAT_CYC_NUM - 1);

    typedef enum logic {
        S_FILL,
        S_WAIT
    } state_e;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ptr_q, ptr_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [CU_NUM-1:0]     cu_unit_q, cu_unit_d;

    logic [BUS_SIZE-1:0]   sparsemap_q;
    logic [BUS_SIZE*8-1:0] data_q;
    logic [NZ_W-1:0]       nz_q;
    logic                  valid_q;
    logic                  done_q;
    logic [CNT_W-1:0]      count_q;
    logic                  sel_q;
    logic [CU_NUM-1:0]     cu_wr_sel_q;

    logic [BUS_SIZE-1:0]   enc_map;
    logic [BUS_SIZE*8-1:0] enc_data;
    logic [NZ_W-1:0]       enc_count;

    state_e state;
    logic   accept;
    logic   chunk_last;
    logic [1:0] bank_set;

    // The state is fully determined by whether the bank being filled is still occupied.
    assign state      = bank_full_q[ptr_q] ? S_WAIT : S_FILL;
    assign in_ready_o = (state == S_FILL);
    assign accept     = in_valid_i & in_ready_o;
    assign chunk_last = accept & (cnt_q == LAST_BEAT);

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        int unsigned pos;
        enc_map  = '0;
        enc_data = '0;
        pos      = 0;
        for (int k = 0; k < BUS_SIZE; k++) begin
            if (in_data_i[8*k +: 8] != 8'h00) begin
                enc_map[k]             = 1'b1;
                enc_data[8*pos +: 8]   = in_data_i[8*k +: 8];
                pos                    = pos + 1;
            end
        end
        enc_count = NZ_W'(pos);
    end

    always_comb begin
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        cu_unit_d = cu_unit_q;
        bank_set  = 2'b00;
        if (accept) begin
            cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
        end
        if (chunk_last) begin
            ptr_d           = ~ptr_q;
            cu_unit_d       = {cu_unit_q[CU_NUM-2:0], cu_unit_q[CU_NUM-1]};
            bank_set[ptr_q] = 1'b1;
        end
        // A set always wins over a same-cycle release of that bank.
        bank_full_d = (bank_full_q & ~release_i) | bank_set;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            bank_full_q <= 2'b00;
            cu_unit_q   <= CU_NUM'(1);
            sparsemap_q <= '0;
            data_q      <= '0;
            nz_q        <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            sel_q       <= 1'b0;
            cu_wr_sel_q <= CU_NUM'(1);
        end else begin
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            bank_full_q <= bank_full_d;
            cu_unit_q   <= cu_unit_d;
            valid_q     <= accept;
            done_q      <= chunk_last;
            // One extra register stage so the last beat of a chunk still shows the old unit.
            cu_wr_sel_q <= cu_unit_q;
            if (accept) begin
                sparsemap_q <= enc_map;
                data_q      <= enc_data;
                nz_q        <= enc_count;
                count_q     <= cnt_q;
                sel_q       <= ptr_q;
            end
        end
    end

    assign sparsemap_o      = sparsemap_q;
    assign nonzero_data_o   = data_q;
    assign nz_count_o       = nz_q;
    assign chunk_wr_valid_o = valid_q;
    assign chunk_wr_count_o = count_q;
    assign chunk_wr_sel_o   = sel_q;
    assign cu_wr_sel_o      = cu_wr_sel_q;
    assign bank_full_o      = bank_full_q;
    assign chunk_done_o     = done_q;

endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Self-checking bench for sparse_chunk_writer: directed and random beats compared against a
// stream-level reference model (beat index, bank and unit derived from the accepted-beat total).
module tb_sparse_chunk_writer;

    localparam int BUS = 16;
    localparam int CYC = 8;
    localparam int CU  = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [BUS*8-1:0] in_data_i;
    logic [1:0]       release_i;
    logic [BUS-1:0]   sparsemap_o;
    logic [BUS*8-1:0] nonzero_data_o;
    logic [4:0]       nz_count_o;
    logic             chunk_wr_valid_o;
    logic [2:0]       chunk_wr_count_o;
    logic             chunk_wr_sel_o;
    logic [CU-1:0]    cu_wr_sel_o;
    logic [1:0]       bank_full_o;
    logic             chunk_done_o;

    sparse_chunk_writer #(.BUS_SIZE(BUS), .WR_DAT_CYC_NUM(CYC), .CU_NUM(CU)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .release_i       (release_i),
        .sparsemap_o     (sparsemap_o),
        .nonzero_data_o  (nonzero_data_o),
        .nz_count_o      (nz_count_o),
        .chunk_wr_valid_o(chunk_wr_valid_o),
        .chunk_wr_count_o(chunk_wr_count_o),
        .chunk_wr_sel_o  (chunk_wr_sel_o),
        .cu_wr_sel_o     (cu_wr_sel_o),
        .bank_full_o     (bank_full_o),
        .chunk_done_o    (chunk_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: total beats accepted since reset and bank occupancy.
    int             n_acc;
    logic [1:0]     m_full;
    logic [BUS-1:0] e_sm;
    logic [127:0]   e_data;
    int             e_nz;
    int             e_cnt;
    logic           e_sel;
    logic [CU-1:0]  e_cu;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_encode(input logic [127:0] d, output logic [BUS-1:0] sm,
                                       output logic [127:0] nz, output int cnt);
        logic [7:0] q[$];
        sm = '0;
        nz = '0;
        for (int k = 0; k < BUS; k++) begin
            if (d[8*k +: 8] != 8'h00) begin
                sm[k] = 1'b1;
                q.push_back(d[8*k +: 8]);
            end
        end
        foreach (q[j]) nz[8*j +: 8] = q[j];
        cnt = q.size();
    endfunction

    function automatic logic [127:0] rand_nonzero();
        logic [127:0] d;
        for (int k = 0; k < BUS; k++) d[8*k +: 8] = 8'($urandom_range(1, 255));
        return d;
    endfunction

    function automatic logic [127:0] rand_sparse();
        logic [127:0] d;
        for (int k = 0; k < BUS; k++)
            d[8*k +: 8] = ($urandom % 2 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        return d;
    endfunction

    task automatic model_reset();
        n_acc  = 0;
        m_full = 2'b00;
        e_sm   = '0;
        e_data = '0;
        e_nz   = 0;
        e_cnt  = 0;
        e_sel  = 1'b0;
        e_cu   = CU'(1);
    endtask

    // Called at a falling edge: drive one cycle of inputs, check ready, then check registered outputs.
    task automatic step(input logic v, input logic [127:0] d, input logic [1:0] rel);
        logic mready, acc, last;
        int   bank;
        in_valid_i = v;
        in_data_i  = d;
        release_i  = rel;
        #1;
        bank   = (n_acc / CYC) % 2;
        mready = !m_full[bank];
        check("in_ready", 128'(in_ready_o), 128'(mready));
        acc  = v && mready;
        last = acc && (n_acc % CYC == CYC - 1);
        if (acc) begin
            ref_encode(d, e_sm, e_data, e_nz);
            e_cnt = n_acc % CYC;
            e_sel = bank[0];
            e_cu  = CU'(1 << ((n_acc / CYC) % CU));
            n_acc++;
        end
        m_full = (m_full & ~rel) | (last ? (2'b01 << bank) : 2'b00);
        @(posedge clk_i);
        #1;
        check("wr_valid", 128'(chunk_wr_valid_o), 128'(acc));
        check("chunk_done", 128'(chunk_done_o), 128'(last));
        check("bank_full", 128'(bank_full_o), 128'(m_full));
        check("sparsemap", 128'(sparsemap_o), 128'(e_sm));
        check("nz_data", nonzero_data_o, e_data);
        check("nz_count", 128'(nz_count_o), 128'(e_nz));
        check("wr_count", 128'(chunk_wr_count_o), 128'(e_cnt));
        check("wr_sel", 128'(chunk_wr_sel_o), 128'(e_sel));
        if (acc) check("cu_wr_sel", 128'(cu_wr_sel_o), 128'(e_cu));
        @(negedge clk_i);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 128'(chunk_wr_valid_o), 128'(0));
        check({tag, "_done"}, 128'(chunk_done_o), 128'(0));
        check({tag, "_sm"}, 128'(sparsemap_o), 128'(0));
        check({tag, "_data"}, nonzero_data_o, 128'(0));
        check({tag, "_nz"}, 128'(nz_count_o), 128'(0));
        check({tag, "_cnt"}, 128'(chunk_wr_count_o), 128'(0));
        check({tag, "_sel"}, 128'(chunk_wr_sel_o), 128'(0));
        check({tag, "_cu"}, 128'(cu_wr_sel_o), 128'(4'b0001));
        check({tag, "_full"}, 128'(bank_full_o), 128'(0));
        check({tag, "_ready"}, 128'(in_ready_o), 128'(1));
    endtask

    initial begin
        logic [127:0] pat;
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        release_i  = 2'b00;
        model_reset();
        repeat (3) @(negedge clk_i);
        check_reset_state("reset");
        rst_i = 1'b1;
        @(negedge clk_i);

        // One chunk of a fixed two-nonzero pattern.
        pat = '0;
        pat[8*3 +: 8]  = 8'hA5;
        pat[8*10 +: 8] = 8'h07;
        step(1'b1, pat, 2'b00);
        check("pat_sm", 128'(sparsemap_o), 128'(16'h0408));
        check("pat_data", nonzero_data_o, 128'h07A5);
        check("pat_nz", 128'(nz_count_o), 128'(2));
        repeat (CYC - 1) step(1'b1, pat, 2'b00);
        step(1'b0, '0, 2'b00);
        check("one_chunk_full", 128'(bank_full_o), 128'(2'b01));

        // Second chunk without releases fills bank 1; the 17th beat is held.
        repeat (CYC) step(1'b1, rand_sparse(), 2'b00);
        check("both_full", 128'(bank_full_o), 128'(2'b11));
        repeat (3) step(1'b1, rand_sparse(), 2'b00);

        // Releasing only the other bank must not reopen the write path.
        step(1'b1, rand_sparse(), 2'b10);
        step(1'b1, rand_sparse(), 2'b00);
        check("other_rel_ready", 128'(in_ready_o), 128'(0));
        step(1'b0, '0, 2'b01);
        check("ptr_rel_ready", 128'(in_ready_o), 128'(1));
        repeat (CYC) step(1'b1, rand_sparse(), 2'b00);

        // Random gaps with all-nonzero beats and prompt releases.
        for (int i = 0; i < 60; i++) step(1'($urandom % 2), rand_nonzero(), m_full);

        // Fresh reset, then four-plus chunks back to back so the unit select walks once round.
        rst_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 5 * CYC; i++) step(1'b1, rand_sparse(), m_full);

        // Asynchronous reset in the middle of a chunk.
        rst_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (5) step(1'b1, rand_sparse(), 2'b00);
        #3;
        rst_i = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < CYC + 2; i++) step(1'b1, rand_sparse(), 2'b00);

        // Mixed random traffic with random release pulses.
        for (int i = 0; i < 300; i++)
            step(1'($urandom % 4 != 0), rand_sparse(), ($urandom % 4 == 0) ? 2'($urandom) : 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
